// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD SPI-mode command sequencer with R1 poll and single-block read
//
// Purpose: frames one SD command through the byte-level spi block, polls for
// R1, optionally waits for the data start token and streams one block out.
// Ports:
//   clk, reset (async, active-low)
//   start, cmd_index, cmd_arg, cmd_crc, read_data : command request
//   busy, done, r1, timeout, token_err            : status
//   data_out, data_valid                          : block byte stream
//   spi_enable, spi_rnw, spi_addr, spi_din        : spi register writes
//   spi_dout                                      : last byte received by spi
module sd_cmd_engine #(
  parameter int BYTE_CYCLES = 20,
  parameter int NCR_MAX     = 8,
  parameter int TOKEN_MAX   = 4096,
  parameter int BLOCK_LEN   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        read_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        token_err,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        spi_enable,
  output logic        spi_rnw,
  output logic [2:0]  spi_addr,
  output logic [7:0]  spi_din,
  input  logic [7:0]  spi_dout
);

  typedef enum logic [3:0] {
    S_IDLE, S_CS_LO, S_SEND, S_POLL_R1, S_TOKEN,
    S_DATA, S_CRC, S_CS_HI, S_TRAIL, S_DONE
  } state_t;

  localparam logic [4:0]  LAST_WAIT  = 5'(BYTE_CYCLES);
  localparam logic [12:0] NCR_LAST   = 13'(NCR_MAX - 1);
  localparam logic [12:0] TOKEN_LAST = 13'(TOKEN_MAX - 1);
  localparam logic [9:0]  BLOCK_LAST = 10'(BLOCK_LEN - 1);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_DUMMY = 3'd1;
  localparam logic [2:0] A_CS_HI = 3'd3;
  localparam logic [2:0] A_CS_LO = 3'd4;

  state_t      state;
  logic [4:0]  wcnt;
  logic [9:0]  bcnt;
  logic [12:0] pcnt;
  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic        rd_q;
  logic        last_wait;
  logic [7:0]  next_frame;

  // Every exchange issues on wcnt==0 and samples spi_dout on wcnt==BYTE_CYCLES.
  assign last_wait = (wcnt == LAST_WAIT);

  // Frame byte following the one currently in flight (byte 0 is sent on SEND entry).
  always_comb begin
    next_frame = {crc_q, 1'b1};
    case (bcnt[2:0])
      3'd0:    next_frame = arg_q[31:24];
      3'd1:    next_frame = arg_q[23:16];
      3'd2:    next_frame = arg_q[15:8];
      3'd3:    next_frame = arg_q[7:0];
      default: next_frame = {crc_q, 1'b1};
    endcase
  end

  // Transitions that start an exchange also load the spi write registers, so
  // spi_enable is high during the first cycle of the new exchange.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      bcnt       <= '0;
      pcnt       <= '0;
      idx_q      <= '0;
      arg_q      <= '0;
      crc_q      <= '0;
      rd_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r1         <= 8'hFF;
      timeout    <= 1'b0;
      token_err  <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      spi_enable <= 1'b0;
      spi_rnw    <= 1'b1;
      spi_addr   <= 3'd0;
      spi_din    <= 8'h00;
    end else begin
      spi_enable <= 1'b0;
      data_valid <= 1'b0;
      done       <= 1'b0;
      wcnt       <= wcnt + 5'd1;
      case (state)
        S_IDLE: begin
          wcnt <= '0;
          if (start) begin
            idx_q      <= cmd_index;
            arg_q      <= cmd_arg;
            crc_q      <= cmd_crc;
            rd_q       <= read_data;
            busy       <= 1'b1;
            timeout    <= 1'b0;
            token_err  <= 1'b0;
            state      <= S_CS_LO;
            spi_enable <= 1'b1;
            spi_rnw    <= 1'b0;
            spi_addr   <= A_CS_LO;
          end
        end
        S_CS_LO: begin
          // Issue cycle then one idle cycle before the frame starts.
          if (wcnt == 5'd1) begin
            state <= S_SEND; bcnt <= '0; wcnt <= '0;
            spi_enable <= 1'b1; spi_addr <= A_DATA; spi_din <= {2'b01, idx_q};
          end
        end
        S_SEND: begin
          if (last_wait) begin
            wcnt <= '0; spi_enable <= 1'b1;
            if (bcnt == 10'd5) begin
              state <= S_POLL_R1; pcnt <= '0; bcnt <= '0;
              spi_addr <= A_DUMMY; spi_din <= 8'hFF;
            end else begin
              bcnt <= bcnt + 10'd1;
              spi_addr <= A_DATA; spi_din <= next_frame;
            end
          end
        end
        S_POLL_R1: begin
          if (last_wait) begin
            wcnt <= '0; spi_enable <= 1'b1; spi_din <= 8'hFF;
            if (!spi_dout[7]) begin
              r1 <= spi_dout;
              // Only a clean R1 (no error bits) moves on to the data token.
              if (rd_q && spi_dout[7:1] == 7'd0) begin
                state <= S_TOKEN; pcnt <= '0; spi_addr <= A_DUMMY;
              end else begin
                state <= S_CS_HI; spi_addr <= A_CS_HI;
              end
            end else if (pcnt == NCR_LAST) begin
              timeout <= 1'b1; r1 <= spi_dout;
              state <= S_CS_HI; spi_addr <= A_CS_HI;
            end else begin
              pcnt <= pcnt + 13'd1; spi_addr <= A_DUMMY;
            end
          end
        end
        S_TOKEN: begin
          if (last_wait) begin
            wcnt <= '0; spi_enable <= 1'b1; spi_din <= 8'hFF;
            if (spi_dout == 8'hFE) begin
              state <= S_DATA; bcnt <= '0; spi_addr <= A_DUMMY;
            end else if (spi_dout != 8'hFF) begin
              token_err <= 1'b1; state <= S_CS_HI; spi_addr <= A_CS_HI;
            end else if (pcnt == TOKEN_LAST) begin
              timeout <= 1'b1; state <= S_CS_HI; spi_addr <= A_CS_HI;
            end else begin
              pcnt <= pcnt + 13'd1; spi_addr <= A_DUMMY;
            end
          end
        end
        S_DATA: begin
          if (last_wait) begin
            data_out <= spi_dout; data_valid <= 1'b1;
            wcnt <= '0; spi_enable <= 1'b1; spi_addr <= A_DUMMY; spi_din <= 8'hFF;
            if (bcnt == BLOCK_LAST) begin
              state <= S_CRC; bcnt <= '0;
            end else begin
              bcnt <= bcnt + 10'd1;
            end
          end
        end
        S_CRC: begin
          if (last_wait) begin
            wcnt <= '0; spi_enable <= 1'b1; spi_din <= 8'hFF;
            if (bcnt == 10'd1) begin
              state <= S_CS_HI; spi_addr <= A_CS_HI;
            end else begin
              bcnt <= bcnt + 10'd1; spi_addr <= A_DUMMY;
            end
          end
        end
        S_CS_HI: begin
          // One dummy byte with CS high gives the card its trailing clocks.
          if (wcnt == 5'd1) begin
            state <= S_TRAIL; wcnt <= '0;
            spi_enable <= 1'b1; spi_addr <= A_DUMMY; spi_din <= 8'hFF;
          end
        end
        S_TRAIL: begin
          if (last_wait) begin
            state <= S_DONE; done <= 1'b1; busy <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
